// File: rtl/dft4_stream_ctrl_if.sv
// Stream bundle for dft4_stream_ctrl: the time-domain sample input and the
// frequency-bin output, each with a valid/ready handshake.
interface dft4_stream_ctrl_if #(parameter int N = 32) ();
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_re;
  logic signed [N-1:0] in_im;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_re;
  logic signed [N-1:0] out_im;
  logic [1:0]          out_bin;
  logic                out_last;

  // master is the environment that feeds samples and sinks bins; slave is the controller
  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_bin, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_bin, out_last
  );
endinterface

// File: rtl/dft4_stream_ctrl.sv
// Four-point DFT stream controller: gathers 4 complex samples, transforms them with one
// DFT_4 core and emits bins 0..3. Define DFT4_PINGPONG_EN for double-buffered input capture.

module DFT_4 #(parameter int N = 32) (
  input  logic signed [N-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im,
  output logic signed [N-1:0] fa_re, fa_im, fb_re, fb_im, fc_re, fc_im, fd_re, fd_im
);
  // Bins 1 and 3 rotate the odd samples by -j and +j: a re/im swap with a sign flip.
  assign fa_re = a_re + b_re + c_re + d_re;
  assign fa_im = a_im + b_im + c_im + d_im;
  assign fb_re = a_re + b_im - c_re - d_im;
  assign fb_im = a_im - b_re - c_im + d_re;
  assign fc_re = a_re - b_re + c_re - d_re;
  assign fc_im = a_im - b_im + c_im - d_im;
  assign fd_re = a_re - b_im - c_re + d_im;
  assign fd_im = a_im + b_re - c_im - d_re;
endmodule

module dft4_stream_ctrl #(parameter int N = 32) (
  input  logic              clk,
  input  logic              rst_n,
  dft4_stream_ctrl_if.slave bus,
  output logic [15:0]       frame_cnt
);
  typedef enum logic [1:0] {LOAD = 2'd0, CALC = 2'd1, EMIT = 2'd2} state_t;

  state_t              state;
  logic [1:0]          load_idx;
  logic [1:0]          next_bin;
  logic                accept;
  logic                load_done;
  logic signed [N-1:0] x_re [4];
  logic signed [N-1:0] x_im [4];
  logic signed [N-1:0] core_re [4];
  logic signed [N-1:0] core_im [4];
  logic signed [N-1:0] bin_re [4];
  logic signed [N-1:0] bin_im [4];

  assign accept    = bus.in_valid && bus.in_ready;
  assign load_done = accept && (load_idx == 2'd3);
  assign next_bin  = bus.out_bin + 2'd1;

`ifdef DFT4_PINGPONG_EN
  logic signed [N-1:0] buf_re [2][4];
  logic signed [N-1:0] buf_im [2][4];
  logic                wr_sel;
  logic                rd_sel;
  logic                alt_full;

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_re[wr_sel][load_idx] <= bus.in_re;
      buf_im[wr_sel][load_idx] <= bus.in_im;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      x_re[i] = buf_re[rd_sel][i];
      x_im[i] = buf_im[rd_sel][i];
    end
  end
`else
  logic signed [N-1:0] buf_re [4];
  logic signed [N-1:0] buf_im [4];

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_re[load_idx] <= bus.in_re;
      buf_im[load_idx] <= bus.in_im;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      x_re[i] = buf_re[i];
      x_im[i] = buf_im[i];
    end
  end
`endif

  DFT_4 #(.N(N)) core (
    .a_re (x_re[0]),    .a_im (x_im[0]),
    .b_re (x_re[1]),    .b_im (x_im[1]),
    .c_re (x_re[2]),    .c_im (x_im[2]),
    .d_re (x_re[3]),    .d_im (x_im[3]),
    .fa_re(core_re[0]), .fa_im(core_im[0]),
    .fb_re(core_re[1]), .fb_im(core_im[1]),
    .fc_re(core_re[2]), .fc_im(core_im[2]),
    .fd_re(core_re[3]), .fd_im(core_im[3])
  );

  // in_ready resets high so the first sample can be taken on the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD;
      load_idx      <= 2'd0;
      frame_cnt     <= 16'd0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_re    <= '0;
      bus.out_im    <= '0;
      bus.out_bin   <= 2'd0;
      bus.out_last  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        bin_re[i] <= '0;
        bin_im[i] <= '0;
      end
`ifdef DFT4_PINGPONG_EN
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      alt_full <= 1'b0;
`endif
    end else begin
      if (accept) begin
        load_idx <= load_idx + 2'd1;
      end
      case (state)
        LOAD: begin
          if (load_done) begin
            state        <= CALC;
            bus.in_ready <= 1'b0;
`ifdef DFT4_PINGPONG_EN
            rd_sel <= wr_sel;
            wr_sel <= ~wr_sel;
`endif
          end
        end
        CALC: begin
          for (int i = 0; i < 4; i++) begin
            bin_re[i] <= core_re[i];
            bin_im[i] <= core_im[i];
          end
          state         <= EMIT;
          bus.out_valid <= 1'b1;
          bus.out_re    <= core_re[0];
          bus.out_im    <= core_im[0];
          bus.out_bin   <= 2'd0;
          bus.out_last  <= 1'b0;
`ifdef DFT4_PINGPONG_EN
          bus.in_ready <= 1'b1;
`endif
        end
        EMIT: begin
`ifdef DFT4_PINGPONG_EN
          if (load_done) begin
            alt_full     <= 1'b1;
            bus.in_ready <= 1'b0;
          end
`endif
          if (bus.out_valid && bus.out_ready) begin
            if (bus.out_bin == 2'd3) begin
              frame_cnt     <= frame_cnt + 16'd1;
              bus.out_valid <= 1'b0;
              bus.out_bin   <= 2'd0;
              bus.out_last  <= 1'b0;
`ifdef DFT4_PINGPONG_EN
              // A frame finished filling during EMIT goes straight to the core.
              if (alt_full || load_done) begin
                state        <= CALC;
                bus.in_ready <= 1'b0;
                alt_full     <= 1'b0;
                rd_sel       <= wr_sel;
                wr_sel       <= ~wr_sel;
              end else begin
                state        <= LOAD;
                bus.in_ready <= 1'b1;
              end
`else
              state        <= LOAD;
              bus.in_ready <= 1'b1;
`endif
            end else begin
              bus.out_bin  <= next_bin;
              bus.out_re   <= bin_re[next_bin];
              bus.out_im   <= bin_im[next_bin];
              bus.out_last <= (next_bin == 2'd3);
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dft4_stream_ctrl.sv
// Self-checking bench for dft4_stream_ctrl: directed vectors, backpressure, mid-frame reset
// and random frames against a plain-arithmetic DFT model; DFT4_PINGPONG_EN adds streaming.
module tb_dft4_stream_ctrl;
  localparam int N = 16;
`ifdef DFT4_PINGPONG_EN
  localparam logic BP_READY = 1'b1;
`else
  localparam logic BP_READY = 1'b0;
`endif

  typedef logic signed [N-1:0] word_t;
  typedef struct {
    word_t      re;
    word_t      im;
    logic [1:0] bin;
    logic       last;
  } out_t;
  typedef struct {
    string name;
    word_t x_re [4];
    word_t x_im [4];
    word_t y_re [4];
    word_t y_im [4];
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] frame_cnt;
  int          checks = 0;
  int          errors = 0;
  int          exp_frames = 0;
  out_t        got_q [$];
  out_t        exp_q [$];
  vec_t        vecs [4];

  dft4_stream_ctrl_if #(.N(N)) bus ();

  dft4_stream_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Every bin the sink accepts is recorded; values are stable at the falling edge.
  always @(negedge clk) begin
    out_t o;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      o.re   = bus.out_re;
      o.im   = bus.out_im;
      o.bin  = bus.out_bin;
      o.last = bus.out_last;
      got_q.push_back(o);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: X[k] = sum_n x[n] * (-j)^(n*k), summed wide and wrapped to N bits.
  function automatic void push_model(input word_t xr [4], input word_t xi [4]);
    for (int k = 0; k < 4; k++) begin
      longint sr;
      longint si;
      out_t   e;
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0:       begin sr += xr[n]; si += xi[n]; end
          1:       begin sr += xi[n]; si -= xr[n]; end
          2:       begin sr -= xr[n]; si -= xi[n]; end
          default: begin sr -= xi[n]; si += xr[n]; end
        endcase
      end
      e.re   = word_t'(sr);
      e.im   = word_t'(si);
      e.bin  = 2'(k);
      e.last = (k == 3);
      exp_q.push_back(e);
    end
  endfunction

  function automatic void push_table(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      out_t e;
      e.re   = v.y_re[k];
      e.im   = v.y_im[k];
      e.bin  = 2'(k);
      e.last = (k == 3);
      exp_q.push_back(e);
    end
  endfunction

  task automatic applyStimulus(input word_t re, input word_t im, input int gap);
    logic hs;
    int   cnt;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_re    = re;
    bus.in_im    = im;
    hs  = 1'b0;
    cnt = 0;
    while (!hs && cnt < 100) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("in_handshake", hs, 1);
  endtask

  task automatic send_frame(input word_t xr [4], input word_t xi [4], input int max_gap);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(xr[i], xi[i], $urandom_range(0, max_gap));
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input bit rand_ready);
    int cnt;
    cnt = 0;
    while (got_q.size() < n && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.out_ready = 1'b1;
    checkOutput("output_count", got_q.size(), n);
  endtask

  task automatic compare_outputs(input string tag);
    out_t g;
    out_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({tag, "_bin_present"}, got_q.size() > 0, 1);
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        checkOutput({tag, "_re"}, g.re, e.re);
        checkOutput({tag, "_im"}, g.im, e.im);
        checkOutput({tag, "_bin"}, g.bin, e.bin);
        checkOutput({tag, "_last"}, g.last, e.last);
      end
    end
    checkOutput({tag, "_no_extra_bins"}, got_q.size(), 0);
    checkOutput({tag, "_frame_cnt"}, frame_cnt, exp_frames & 16'hFFFF);
  endtask

  task automatic random_frame(output word_t xr [4], output word_t xi [4]);
    for (int i = 0; i < 4; i++) begin
      xr[i] = word_t'($urandom);
      xi[i] = word_t'($urandom);
    end
  endtask

  initial begin
    word_t xr [4];
    word_t xi [4];
    int    cnt;

    vecs[0].name = "impulse";
    vecs[0].x_re = '{1, 0, 0, 0};   vecs[0].x_im = '{0, 0, 0, 0};
    vecs[0].y_re = '{1, 1, 1, 1};   vecs[0].y_im = '{0, 0, 0, 0};
    vecs[1].name = "dc";
    vecs[1].x_re = '{1, 1, 1, 1};   vecs[1].x_im = '{0, 0, 0, 0};
    vecs[1].y_re = '{4, 0, 0, 0};   vecs[1].y_im = '{0, 0, 0, 0};
    vecs[2].name = "shifted_impulse";
    vecs[2].x_re = '{0, 1, 0, 0};   vecs[2].x_im = '{0, 0, 0, 0};
    vecs[2].y_re = '{1, 0, -1, 0};  vecs[2].y_im = '{0, -1, 0, 1};
    vecs[3].name = "ramp";
    vecs[3].x_re = '{1, 2, 3, 4};   vecs[3].x_im = '{0, 0, 0, 0};
    vecs[3].y_re = '{10, -2, -2, -2}; vecs[3].y_im = '{0, 2, 0, -2};

    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_out_bin", bus.out_bin, 0);
    checkOutput("rst_out_last", bus.out_last, 0);
    checkOutput("rst_out_re", bus.out_re, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_reset", bus.in_ready, 1);

    for (int v = 0; v < 4; v++) begin
      push_table(vecs[v]);
      for (int i = 0; i < 4; i++) applyStimulus(vecs[v].x_re[i], vecs[v].x_im[i], 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput({vecs[v].name, "_valid_cycle1"}, bus.out_valid, 0);
      @(negedge clk);
      checkOutput({vecs[v].name, "_valid_cycle2"}, bus.out_valid, 1);
      wait_outputs(4, 0);
      exp_frames++;
      compare_outputs(vecs[v].name);
    end

    // Backpressure while bin 1 is presented.
    random_frame(xr, xi);
    push_model(xr, xi);
    send_frame(xr, xi, 0);
    cnt = 0;
    while (!(bus.out_valid && bus.out_bin == 2'd1) && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("bp_reach_bin1", bus.out_bin, 1);
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_valid", bus.out_valid, 1);
      checkOutput("bp_re", bus.out_re, exp_q[1].re);
      checkOutput("bp_im", bus.out_im, exp_q[1].im);
      checkOutput("bp_bin", bus.out_bin, 1);
      checkOutput("bp_in_ready", bus.in_ready, BP_READY);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_outputs(4, 0);
    exp_frames++;
    compare_outputs("backpressure");

    // Reset once bin 1 has been accepted.
    random_frame(xr, xi);
    push_model(xr, xi);
    send_frame(xr, xi, 0);
    cnt = 0;
    while (!(bus.out_valid && bus.out_bin == 2'd2) && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("mid_reach_bin2", bus.out_bin, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", bus.out_valid, 0);
    checkOutput("mid_rst_frame_cnt", frame_cnt, 0);
    checkOutput("mid_rst_out_bin", bus.out_bin, 0);
    checkOutput("mid_rst_out_last", bus.out_last, 0);
    got_q.delete();
    exp_q.delete();
    exp_frames = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("no_stale_output", bus.out_valid, 0);
    end
    checkOutput("no_stale_bins", got_q.size(), 0);
    @(posedge clk);
    #1;
    random_frame(xr, xi);
    push_model(xr, xi);
    send_frame(xr, xi, 0);
    wait_outputs(4, 1);
    exp_frames++;
    compare_outputs("after_reset");

    for (int f = 0; f < 12; f++) begin
      random_frame(xr, xi);
      push_model(xr, xi);
      send_frame(xr, xi, 2);
      wait_outputs(4, 1);
      exp_frames++;
      compare_outputs("random");
    end

`ifdef DFT4_PINGPONG_EN
    begin
      word_t pr [12];
      word_t pi [12];
      logic  hs;
      int    k;
      for (int i = 0; i < 12; i++) begin
        pr[i] = word_t'($urandom);
        pi[i] = word_t'($urandom);
      end
      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < 4; i++) begin
          xr[i] = pr[f * 4 + i];
          xi[i] = pi[f * 4 + i];
        end
        push_model(xr, xi);
      end
      bus.out_ready = 1'b1;
      k = 0;
      cnt = 0;
      while (k < 12 && cnt < 200) begin
        bus.in_valid = 1'b1;
        bus.in_re    = pr[k];
        bus.in_im    = pi[k];
        @(negedge clk);
        hs = bus.in_ready;
        if (bus.out_valid) checkOutput("pp_in_ready_emit", bus.in_ready, 1);
        @(posedge clk);
        #1;
        if (hs) k++;
        cnt++;
      end
      bus.in_valid = 1'b0;
      checkOutput("pp_samples_sent", k, 12);
      wait_outputs(12, 0);
      exp_frames += 3;
      compare_outputs("pingpong");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dft4_stream_ctrl.md
DFT4_STREAM_CTRL -- requirements
Module: dft4_stream_ctrl

Interface
REQ-001 SHALL have parameter N, default 32: sample component width in bits (two's complement).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_re and in_im (input, N each): time-domain sample stream.
REQ-005 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_re and out_im (output, N each): frequency-bin stream.
REQ-006 SHALL have ports out_bin (output, 2): index of the current bin (0..3); out_last (output, 1): high with bin 3.
REQ-007 SHALL have port frame_cnt (output, 16): count of completed output frames.

Function
REQ-008 SHALL instantiate one DFT_4 #(N) core as the sole arithmetic resource, with a=x0, b=x1, c=x2, d=x3, and bins X0..X3 taken from A..D.
REQ-009 SHALL accept an input sample only when in_valid and in_ready are both high in the same cycle.
REQ-010 SHALL store accepted samples x0..x3 in arrival order, using a 2-bit load index that wraps 3->0.
REQ-011 SHALL implement states LOAD, CALC and EMIT; reset state LOAD.
REQ-012 LOAD SHALL drive in_ready=1 and move to CALC on the cycle the fourth sample is accepted.
REQ-013 CALC SHALL last exactly one cycle: it registers the core's eight outputs into the bin registers and moves to EMIT.
REQ-014 EMIT SHALL drive out_valid=1 and present bins in order 0,1,2,3; the bin index advances only on an out_valid&&out_ready cycle.
REQ-015 out_re, out_im, out_bin and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-016 On acceptance of bin 3, EMIT SHALL increment frame_cnt (wrapping 0xFFFF->0) and return to LOAD.
REQ-017 Latency SHALL be exactly 2 cycles from the fourth input handshake edge to out_valid=1 for bin 0.
REQ-018 Bin results SHALL be N bits, as produced by the core; overflow wraps and is not detected.
REQ-019 out_valid SHALL be 0 in LOAD and CALC.
REQ-020 in_ready SHALL be 0 in CALC and EMIT, except where REQ-026 applies.

Reset
REQ-021 Asserting rst_n low SHALL immediately force state LOAD, the load and bin indices to 0, frame_cnt 0, out_valid 0, out_re/out_im/out_bin 0 and out_last 0.
REQ-022 A partially loaded or partially emitted frame SHALL be discarded on reset; no output follows from it.
REQ-023 After rst_n deasserts, in_ready SHALL be 1 on the first clock edge.

Configuration
REQ-024 Macro DFT4_PINGPONG_EN SHALL select double-buffered input capture.
REQ-025 Without DFT4_PINGPONG_EN, a single 4-sample buffer SHALL be used, and in_ready SHALL be 0 throughout CALC and EMIT.
REQ-026 With DFT4_PINGPONG_EN, two buffers SHALL alternate:
- in_ready stays 1 during EMIT while the alternate buffer is not full.
- When EMIT of bin 3 completes and the alternate buffer is full, the state goes directly to CALC on that buffer.
- frame_cnt and latency otherwise follow REQ-016 and REQ-017.

Verification
REQ-027 Impulse: send x=(1,0),(0,0),(0,0),(0,0) with out_ready=1 -> all four bins are (1,0); out_last is high on bin 3; frame_cnt=1.
REQ-028 DC: send x=(1,0) four times -> bins (4,0),(0,0),(0,0),(0,0); out_valid rises exactly 2 cycles after the fourth handshake.
REQ-029 Shifted impulse: send x=(0,0),(1,0),(0,0),(0,0) -> bins (1,0),(0,-1),(-1,0),(0,1).
REQ-030 Backpressure: hold out_ready=0 for 5 cycles during bin 1 -> out_re, out_im and out_bin are held constant and in_ready=0 (without the macro); no bin is lost or repeated.
REQ-031 Reset mid-EMIT: drop rst_n after bin 1 is accepted -> out_valid=0 and frame_cnt=0 immediately; the next frame emits from bin 0 with correct values.
REQ-032 With DFT4_PINGPONG_EN: stream 3 back-to-back frames with in_valid=1 and out_ready=1 throughout -> in_ready remains high during EMIT; frame_cnt=3; all bins are correct.
